// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes, issue unit codes, instruction field positions and
// the fetch/issue FSM state encoding shared by the front-end files.
package fetch_pkg;

    // Major opcodes in inst[31:28]
    localparam logic [3:0] OP_HALT = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_BGT  = 4'b1010;
    localparam logic [3:0] OP_LW   = 4'b1100;
    localparam logic [3:0] OP_SW   = 4'b1101;
    localparam logic [3:0] OP_J    = 4'b1110;
    localparam logic [3:0] OP_MV   = 4'b1111;

    // Reservation-station unit codes carried on iss_unit
    typedef enum logic [2:0] {
        UNIT_LW   = 3'b000,
        UNIT_SW   = 3'b001,
        UNIT_ADD  = 3'b010,
        UNIT_MUL  = 3'b011,
        UNIT_MV   = 3'b100,
        UNIT_HALT = 3'b101
    } unit_e;

    // Instruction field positions (msb of each field)
    localparam int OP_HI      = 31;
    localparam int REG1_HI    = 27;
    localparam int REG2_HI    = 21;
    localparam int REG3_HI    = 15;
    localparam int HASIMM_BIT = 0;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DECODE = 3'd2,
        ST_BRANCH = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

endpackage

// File: rtl/fetch_issue_if.sv
// fetch_issue_if: instruction-cache request/response, issue slot and branch
// operand lookup between the front end (master) and cache/RS side (slave).
interface fetch_issue_if #(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 1024,
    parameter int REG_W   = 6
);
    logic               ic_req;
    logic [WORD_W-1:0]  ic_addr;
    logic               ic_rsp_valid;
    logic [BLOCK_W-1:0] ic_rsp_block;

    logic               iss_valid;
    logic               iss_ready;
    logic [2:0]         iss_unit;
    logic [REG_W-1:0]   iss_reg1;
    logic [REG_W-1:0]   iss_reg2;
    logic [REG_W-1:0]   iss_reg3;
    logic               iss_hasimm;
    logic [WORD_W-1:0]  iss_imm;
    logic [WORD_W-1:0]  iss_pc;

    logic [REG_W-1:0]   br_rs_a;
    logic [REG_W-1:0]   br_rs_b;
    logic               br_ready;
    logic [WORD_W-1:0]  br_va;
    logic [WORD_W-1:0]  br_vb;

    logic               halted;

    modport master (
        output ic_req, ic_addr,
        input  ic_rsp_valid, ic_rsp_block,
        output iss_valid, iss_unit, iss_reg1, iss_reg2, iss_reg3,
        output iss_hasimm, iss_imm, iss_pc,
        input  iss_ready,
        output br_rs_a, br_rs_b,
        input  br_ready, br_va, br_vb,
        output halted
    );

    modport slave (
        input  ic_req, ic_addr,
        output ic_rsp_valid, ic_rsp_block,
        input  iss_valid, iss_unit, iss_reg1, iss_reg2, iss_reg3,
        input  iss_hasimm, iss_imm, iss_pc,
        output iss_ready,
        input  br_rs_a, br_rs_b,
        output br_ready, br_va, br_vb,
        input  halted
    );

endinterface

// File: rtl/fetch_decode.sv
// fetch_decode: purely combinational decode of one instruction word into
// issue fields plus branch/jump classification and their offsets.
module fetch_decode
    import fetch_pkg::*;
#(
    parameter int WORD_W = 32,
    parameter int REG_W  = 6
) (
    input  logic [WORD_W-1:0] inst,
    output logic              is_issue,
    output logic              is_bgt,
    output logic              is_j,
    output logic              is_halt,
    output unit_e             unit,
    output logic [REG_W-1:0]  reg1,
    output logic [REG_W-1:0]  reg2,
    output logic [REG_W-1:0]  reg3,
    output logic              hasimm,
    output logic [WORD_W-1:0] imm,
    output logic [WORD_W-1:0] br_off,
    output logic [WORD_W-1:0] j_off
);

    logic [3:0] op;

    // Classify the word and extract its fields
    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        op       = inst[OP_HI -: 4];
        is_issue = 1'b0;
        is_bgt   = 1'b0;
        is_j     = 1'b0;
        is_halt  = 1'b0;
        unit     = UNIT_LW;
        imm      = '0;
        reg1     = inst[REG1_HI -: REG_W];
        reg2     = inst[REG2_HI -: REG_W];
        reg3     = inst[REG3_HI -: REG_W];
        hasimm   = inst[HASIMM_BIT];
        br_off   = WORD_W'($signed(inst[15:0]));
        j_off    = WORD_W'($signed(inst[27:0]));

        case (op)
            OP_ADD: begin is_issue = 1'b1; unit = UNIT_ADD; imm = WORD_W'($signed(inst[15:1])); end
            OP_MUL: begin is_issue = 1'b1; unit = UNIT_MUL; imm = WORD_W'($signed(inst[15:1])); end
            OP_LW:  begin is_issue = 1'b1; unit = UNIT_LW;  imm = WORD_W'($signed(inst[15:1])); end
            OP_SW:  begin is_issue = 1'b1; unit = UNIT_SW;  imm = WORD_W'($signed(inst[15:1])); end
            OP_MV:  begin is_issue = 1'b1; unit = UNIT_MV;  imm = WORD_W'($signed(inst[21:1])); end
            OP_HALT: begin is_issue = 1'b1; is_halt = 1'b1; unit = UNIT_HALT; end
            OP_BGT: is_bgt = 1'b1;
            OP_J:   is_j   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/fetch_issue.sv
// fetch_issue: instruction front end. Fetches cache blocks, walks them one
// word per cycle, issues ops over a valid/ready slot and resolves bgt/j locally.
// Optional feature: define FETCH_PREFETCH_EN for a second block buffer that
// prefetches the sequential next block while decoding.
module fetch_issue
    import fetch_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 1024,
    parameter int REG_W   = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_issue_if.master bus
);

    localparam int BLOCK_BYTES = BLOCK_W / 8;
    localparam int OFF_W       = $clog2(BLOCK_BYTES);
    localparam int WPB         = BLOCK_W / WORD_W;
    localparam int WP_W        = OFF_W - 2;

    function automatic logic [WORD_W-1:0] align(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;

`ifdef FETCH_PREFETCH_EN
    logic [BLOCK_W-1:0] nxt_q, nxt_d;
    logic               nxt_valid_q, nxt_valid_d;
    logic               pf_out_q, pf_out_d;
    logic [WORD_W-1:0]  pf_addr_q, pf_addr_d;
    logic               drop_q, drop_d;
`endif

    logic [WP_W-1:0]    wp;
    logic               last_word;
    logic [WORD_W-1:0]  cur_word;
    logic               do_adv, do_redir;
    logic [WORD_W-1:0]  redir_pc;

    logic               dec_is_issue, dec_is_bgt, dec_is_j, dec_is_halt;
    unit_e              dec_unit;
    logic [REG_W-1:0]   dec_reg1, dec_reg2, dec_reg3;
    logic               dec_hasimm;
    logic [WORD_W-1:0]  dec_imm, dec_br_off, dec_j_off;

    assign wp        = pc_q[OFF_W-1:2];
    assign last_word = &wp;

    // Select the word under the word pointer; word 0 sits in the top bits
    always_comb begin
        cur_word = '0;
        for (int i = 0; i < WPB; i++) begin
            if (wp == WP_W'(i)) cur_word = blk_q[BLOCK_W-1-i*WORD_W -: WORD_W];
        end
    end

    fetch_decode #(.WORD_W(WORD_W), .REG_W(REG_W)) u_decode (
        .inst     (cur_word),
        .is_issue (dec_is_issue),
        .is_bgt   (dec_is_bgt),
        .is_j     (dec_is_j),
        .is_halt  (dec_is_halt),
        .unit     (dec_unit),
        .reg1     (dec_reg1),
        .reg2     (dec_reg2),
        .reg3     (dec_reg3),
        .hasimm   (dec_hasimm),
        .imm      (dec_imm),
        .br_off   (dec_br_off),
        .j_off    (dec_j_off)
    );

    // Control state register with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            pc_q        <= '0;
`ifdef FETCH_PREFETCH_EN
            nxt_valid_q <= 1'b0;
            pf_out_q    <= 1'b0;
            pf_addr_q   <= '0;
            drop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
`ifdef FETCH_PREFETCH_EN
            nxt_valid_q <= nxt_valid_d;
            pf_out_q    <= pf_out_d;
            pf_addr_q   <= pf_addr_d;
            drop_q      <= drop_d;
`endif
        end
    end

    // Block buffers hold data only; their contents are qualified by the FSM
    always_ff @(posedge clk) begin
        // NOTE: wide data buffers are not reset; state/valid flags gate their use.
        blk_q <= blk_d;
`ifdef FETCH_PREFETCH_EN
        nxt_q <= nxt_d;
`endif
    end

    // Next state, PC and buffer updates
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        blk_d    = blk_q;
        do_adv   = 1'b0;
        do_redir = 1'b0;
        redir_pc = pc_q;
`ifdef FETCH_PREFETCH_EN
        nxt_d       = nxt_q;
        nxt_valid_d = nxt_valid_q;
        pf_out_d    = pf_out_q;
        pf_addr_d   = pf_addr_q;
        drop_d      = drop_q;
        // Prefetch response outside WAIT fills the second buffer unless stale
        if (pf_out_q && bus.ic_rsp_valid && state_q != ST_WAIT) begin
            pf_out_d = 1'b0;
            drop_d   = 1'b0;
            if (!drop_q) begin
                nxt_d       = bus.ic_rsp_block;
                nxt_valid_d = 1'b1;
            end
        end
`endif

        unique case (state_q)
            ST_FETCH: begin
`ifdef FETCH_PREFETCH_EN
                // A stale prefetch must drain before a new request goes out
                if (!pf_out_q) state_d = ST_WAIT;
`else
                state_d = ST_WAIT;
`endif
            end
            ST_WAIT: begin
                if (bus.ic_rsp_valid) begin
                    blk_d   = bus.ic_rsp_block;
                    state_d = ST_DECODE;
`ifdef FETCH_PREFETCH_EN
                    pf_out_d = 1'b0;
`endif
                end
            end
            ST_DECODE: begin
                if (dec_is_issue) begin
                    if (bus.iss_ready) begin
                        if (dec_is_halt) begin
                            state_d = ST_HALT;
`ifdef FETCH_PREFETCH_EN
                            nxt_valid_d = 1'b0;
                            if (pf_out_d) drop_d = 1'b1;
`endif
                        end else begin
                            do_adv = 1'b1;
                        end
                    end
                end else if (dec_is_bgt) begin
                    state_d = ST_BRANCH;
                end else if (dec_is_j) begin
                    do_redir = 1'b1;
                    redir_pc = pc_q + dec_j_off;
                end else begin
                    do_adv = 1'b1;
                end
            end
            ST_BRANCH: begin
                if (bus.br_ready) begin
                    if ($signed(bus.br_va) > $signed(bus.br_vb)) begin
                        do_redir = 1'b1;
                        redir_pc = pc_q + dec_br_off;
                    end else begin
                        do_adv = 1'b1;
                    end
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase

        if (do_adv) begin
            pc_d    = pc_q + WORD_W'(4);
            state_d = ST_DECODE;
            if (last_word) begin
`ifdef FETCH_PREFETCH_EN
                if (nxt_valid_q) begin
                    blk_d       = nxt_q;
                    nxt_valid_d = 1'b0;
                end else if (pf_out_q && !drop_q && bus.ic_rsp_valid) begin
                    blk_d       = bus.ic_rsp_block;
                    nxt_valid_d = 1'b0;
                end else if (pf_out_q && !drop_q) begin
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_FETCH;
                end
`else
                state_d = ST_FETCH;
`endif
            end
        end

        if (do_redir) begin
            pc_d = redir_pc;
`ifdef FETCH_PREFETCH_EN
            nxt_valid_d = 1'b0;
            if (pf_out_d) drop_d = 1'b1;
            state_d = (align(redir_pc) == align(pc_q)) ? ST_DECODE : ST_FETCH;
`else
            state_d = ST_FETCH;
`endif
        end

`ifdef FETCH_PREFETCH_EN
        // Request the block after the one being decoded, once per block
        if (state_d == ST_DECODE && !pf_out_d && !nxt_valid_d) begin
            pf_out_d  = 1'b1;
            pf_addr_d = align(pc_d) + WORD_W'(BLOCK_BYTES);
        end
`endif
    end

    // Outputs decoded from state; issue fields are zero unless the slot is valid
    always_comb begin
`ifdef FETCH_PREFETCH_EN
        bus.ic_req  = (state_q == ST_WAIT) || pf_out_q;
        bus.ic_addr = pf_out_q ? pf_addr_q : align(pc_q);
`else
        bus.ic_req  = (state_q == ST_WAIT);
        bus.ic_addr = align(pc_q);
`endif
        bus.iss_valid  = 1'b0;
        bus.iss_unit   = '0;
        bus.iss_reg1   = '0;
        bus.iss_reg2   = '0;
        bus.iss_reg3   = '0;
        bus.iss_hasimm = 1'b0;
        bus.iss_imm    = '0;
        bus.iss_pc     = '0;
        bus.br_rs_a    = '0;
        bus.br_rs_b    = '0;
        bus.halted     = (state_q == ST_HALT);

        if (state_q == ST_DECODE && dec_is_issue) begin
            bus.iss_valid  = 1'b1;
            bus.iss_unit   = dec_unit;
            bus.iss_reg1   = dec_reg1;
            bus.iss_reg2   = dec_reg2;
            bus.iss_reg3   = dec_reg3;
            bus.iss_hasimm = dec_hasimm;
            bus.iss_imm    = dec_imm;
            bus.iss_pc     = pc_q;
        end

        if (state_q == ST_BRANCH) begin
            bus.br_rs_a = dec_reg1;
            bus.br_rs_b = dec_reg2;
        end
    end

endmodule

// File: tb/tb_fetch_issue.sv
// tb_fetch_issue: directed vectors with hand-computed expectations for the
// fetch/issue front end (default single-buffer build).
module tb_fetch_issue;

    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 1024;
    localparam int REG_W   = 6;

    // Hand-encoded instructions
    localparam logic [31:0] I_ADD  = 32'h8042_000B; // add r1,r2,#5
    localparam logic [31:0] I_MUL  = 32'h90C1_0800; // mul r3,r1,r2
    localparam logic [31:0] I_HALT = 32'h1000_0000; // halt
    localparam logic [31:0] I_BGT  = 32'hA042_0008; // bgt r1,r2,+8
    localparam logic [31:0] I_J128 = 32'hE000_0080; // j +128
    localparam logic [31:0] I_JM4  = 32'hEFFF_FFFC; // j -4

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_issue_if #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .REG_W(REG_W)) bus ();

    fetch_issue #(.WORD_W(WORD_W), .BLOCK_W(BLOCK_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int hs_cnt   = 0;
    int vld_cnt  = 0;
    int hs_base;
    int vld_base;

    logic [BLOCK_W-1:0] blk_a, blk_b, blk_h, blk_4a, blk_4b;

    // Count handshakes and valid cycles at each active edge
    always @(posedge clk) begin
        if (bus.iss_valid && bus.iss_ready) hs_cnt <= hs_cnt + 1;
        if (bus.iss_valid) vld_cnt <= vld_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [BLOCK_W-1:0] put(input logic [BLOCK_W-1:0] b, input int idx,
                                               input logic [31:0] w);
        logic [BLOCK_W-1:0] r;
        r = b;
        r[BLOCK_W-1-idx*WORD_W -: WORD_W] = w;
        return r;
    endfunction

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.ic_rsp_valid = 1'b0;
        bus.ic_rsp_block = '0;
        bus.iss_ready    = 1'b1;
        bus.br_ready     = 1'b0;
        bus.br_va        = '0;
        bus.br_vb        = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input string tag, input logic [31:0] exp_addr);
        int n;
        n = 0;
        while (!bus.ic_req && n < 80) begin
            step();
            n++;
        end
        check({tag, " ic_req"}, 32'(bus.ic_req), 32'd1);
        check({tag, " ic_addr"}, bus.ic_addr, exp_addr);
    endtask

    task automatic serve(input logic [BLOCK_W-1:0] blk);
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_block = blk;
        step();
        bus.ic_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        blk_a  = put(put(put('0, 0, I_ADD), 1, I_MUL), 3, I_HALT);
        blk_b  = put(put(put(put('0, 0, I_ADD), 1, I_BGT), 2, I_MUL), 3, I_HALT);
        blk_h  = put('0, 0, I_HALT);
        blk_4a = put(put(put('0, 0, I_J128), 30, I_ADD), 31, I_HALT);
        blk_4b = put(put('0, 0, I_JM4), 1, I_ADD);

        // ---- reset state ----
        rst_n            = 1'b0;
        bus.ic_rsp_valid = 1'b0;
        bus.ic_rsp_block = '0;
        bus.iss_ready    = 1'b1;
        bus.br_ready     = 1'b0;
        bus.br_va        = '0;
        bus.br_vb        = '0;
        step();
        check("rst ic_req", 32'(bus.ic_req), 32'd0);
        check("rst ic_addr", bus.ic_addr, 32'd0);
        check("rst iss_valid", 32'(bus.iss_valid), 32'd0);
        check("rst halted", 32'(bus.halted), 32'd0);
        check("rst br_rs_a", 32'(bus.br_rs_a), 32'd0);
        step();
        rst_n = 1'b1;

        // ---- 1: add, mul, skip, halt ----
        hs_base = hs_cnt;
        wait_req("t1", 32'd0);
        serve(blk_a);
        check("t1 latency valid", 32'(bus.iss_valid), 32'd1);
        check("t1 add unit", 32'(bus.iss_unit), 32'd2);
        check("t1 add imm", bus.iss_imm, 32'd5);
        check("t1 add pc", bus.iss_pc, 32'd0);
        check("t1 add reg1", 32'(bus.iss_reg1), 32'd1);
        check("t1 add reg2", 32'(bus.iss_reg2), 32'd2);
        check("t1 add hasimm", 32'(bus.iss_hasimm), 32'd1);
        step();
        check("t1 mul unit", 32'(bus.iss_unit), 32'd3);
        check("t1 mul reg1", 32'(bus.iss_reg1), 32'd3);
        check("t1 mul reg3", 32'(bus.iss_reg3), 32'd2);
        check("t1 mul imm", bus.iss_imm, 32'h400);
        check("t1 mul pc", bus.iss_pc, 32'd4);
        step();
        check("t1 nop no issue", 32'(bus.iss_valid), 32'd0);
        step();
        check("t1 halt valid", 32'(bus.iss_valid), 32'd1);
        check("t1 halt unit", 32'(bus.iss_unit), 32'd5);
        check("t1 halt pc", bus.iss_pc, 32'd12);
        step();
        check("t1 halted", 32'(bus.halted), 32'd1);
        check("t1 post-halt valid", 32'(bus.iss_valid), 32'd0);
        step(); step(); step();
        check("t1 halted sticky", 32'(bus.halted), 32'd1);
        check("t1 no req after halt", 32'(bus.ic_req), 32'd0);
        check("t1 issue count", 32'(hs_cnt - hs_base), 32'd3);

        // ---- 2: backpressure on first op ----
        do_reset();
        bus.iss_ready = 1'b0;
        hs_base = hs_cnt;
        wait_req("t2", 32'd0);
        serve(blk_a);
        for (int c = 0; c < 4; c++) begin
            check("t2 hold valid", 32'(bus.iss_valid), 32'd1);
            check("t2 hold unit", 32'(bus.iss_unit), 32'd2);
            check("t2 hold pc", bus.iss_pc, 32'd0);
            check("t2 hold imm", bus.iss_imm, 32'd5);
            if (c < 3) step();
        end
        bus.iss_ready = 1'b1;
        step();
        check("t2 2nd unit", 32'(bus.iss_unit), 32'd3);
        check("t2 2nd pc", bus.iss_pc, 32'd4);
        step(); step(); step();
        check("t2 halted", 32'(bus.halted), 32'd1);
        check("t2 issue count", 32'(hs_cnt - hs_base), 32'd3);

        // ---- 3a: bgt taken ----
        do_reset();
        hs_base = hs_cnt;
        wait_req("t3a", 32'd0);
        serve(blk_b);
        step();
        check("t3a bgt no issue", 32'(bus.iss_valid), 32'd0);
        step();
        check("t3a br_rs_a", 32'(bus.br_rs_a), 32'd1);
        check("t3a br_rs_b", 32'(bus.br_rs_b), 32'd2);
        step(); step();
        check("t3a branch wait", 32'(bus.br_rs_a), 32'd1);
        bus.br_ready = 1'b1;
        bus.br_va    = 32'd7;
        bus.br_vb    = 32'd3;
        step();
        bus.br_ready = 1'b0;
        wait_req("t3a refetch", 32'd0);
        serve(blk_b);
        check("t3a target valid", 32'(bus.iss_valid), 32'd1);
        check("t3a target pc", bus.iss_pc, 32'd12);
        check("t3a target unit", 32'(bus.iss_unit), 32'd5);
        check("t3a issue count", 32'(hs_cnt - hs_base), 32'd1);

        // ---- 3b: bgt not taken ----
        do_reset();
        wait_req("t3b", 32'd0);
        serve(blk_b);
        step(); step(); step(); step();
        bus.br_ready = 1'b1;
        bus.br_va    = 32'd3;
        bus.br_vb    = 32'd7;
        step();
        bus.br_ready = 1'b0;
        check("t3b fall valid", 32'(bus.iss_valid), 32'd1);
        check("t3b fall pc", bus.iss_pc, 32'd8);
        check("t3b fall unit", 32'(bus.iss_unit), 32'd3);
        check("t3b no refetch", 32'(bus.ic_req), 32'd0);

        // ---- 4: j -4 at pc 128 ----
        do_reset();
        wait_req("t4", 32'd0);
        vld_base = vld_cnt;
        serve(blk_4a);
        wait_req("t4 j128", 32'd128);
        serve(blk_4b);
        wait_req("t4 jm4", 32'd0);
        serve(blk_4a);
        check("t4 first valid", 32'(bus.iss_valid), 32'd1);
        check("t4 first pc", bus.iss_pc, 32'd124);
        check("t4 first unit", 32'(bus.iss_unit), 32'd5);
        check("t4 nothing earlier", 32'(vld_cnt - vld_base), 32'd0);

        // ---- 5: all-zero block ----
        do_reset();
        wait_req("t5", 32'd0);
        vld_base = vld_cnt;
        serve('0);
        wait_req("t5 next", 32'd128);
        check("t5 no valid", 32'(vld_cnt - vld_base), 32'd0);

        // ---- 6: reset while issue held ----
        do_reset();
        bus.iss_ready = 1'b0;
        wait_req("t6", 32'd0);
        serve(blk_a);
        step();
        check("t6 held valid", 32'(bus.iss_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6 rst valid", 32'(bus.iss_valid), 32'd0);
        check("t6 rst unit", 32'(bus.iss_unit), 32'd0);
        check("t6 rst pc", bus.iss_pc, 32'd0);
        check("t6 rst imm", bus.iss_imm, 32'd0);
        check("t6 rst reg1", 32'(bus.iss_reg1), 32'd0);
        check("t6 rst ic_req", 32'(bus.ic_req), 32'd0);
        step();
        rst_n            = 1'b1;
        bus.iss_ready    = 1'b1;
        bus.ic_rsp_valid = 1'b1;
        bus.ic_rsp_block = blk_a;
        step();
        bus.ic_rsp_valid = 1'b0;
        check("t6 req after rst", 32'(bus.ic_req), 32'd1);
        check("t6 addr after rst", bus.ic_addr, 32'd0);
        check("t6 unsolicited ignored", 32'(bus.iss_valid), 32'd0);
        serve(blk_h);
        check("t6 fresh unit", 32'(bus.iss_unit), 32'd5);
        check("t6 fresh pc", bus.iss_pc, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
